player_anim_sequencer: RTL and testbench

Animation controller for the player sprite. Each frame_Clk tick (one per video frame), it picks the player's animation state from the gameplay inputs and advances a frame index at a fixed tick rate. It outputs the 21-bit sprite-ROM base offset of the current animation frame. The per-pixel player address generator adds this offset to its in-sprite pixel offset.

---
 rtl/player_anim_sequencer.sv | 137 +++++++++++++
 tb/tb_player_anim_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/player_anim_sequencer.sv
// Player sprite animation sequencer: picks IDLE/RUN/JUMP/DIE from gameplay
// inputs once per video frame and produces the sprite-ROM base offset.
//
// state | meaning
// IDLE  | standing still, single frame 0
// RUN   | horizontal motion, frames loop RUN_BASE..RUN_BASE+RUN_FRAMES-1
// JUMP  | airborne, frames loop JUMP_BASE..JUMP_BASE+JUMP_FRAMES-1
// DIE   | absorbing death sequence, saturates on last frame; only Reset exits
module player_anim_sequencer #(
    parameter logic [20:0] FRAME_SIZE      = 21'd3264,
    parameter int          TICKS_PER_FRAME = 4,
    parameter int          RUN_FRAMES      = 6,
    parameter int          JUMP_FRAMES     = 4,
    parameter int          DIE_FRAMES      = 3,
    parameter int          RUN_BASE        = 1,
    parameter int          JUMP_BASE       = 7,
    parameter int          DIE_BASE        = 11,
    parameter logic [20:0] LEFT_BANK       = 21'd45696
) (
    input  logic        frame_Clk,
    input  logic        Reset,
    input  logic        moving,
    input  logic        jumping,
    input  logic        dead,
    input  logic        playerDirection,
    output logic [20:0] frameOffset,
    output logic [1:0]  animState,
    output logic [2:0]  frameIndex,
    output logic        animDone
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        JUMP = 2'd2,
        DIE  = 2'd3
    } animState_t;

    localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_FRAME - 1);
    localparam logic [2:0] RUN_LAST  = 3'(RUN_FRAMES - 1);
    localparam logic [2:0] JUMP_LAST = 3'(JUMP_FRAMES - 1);
    localparam logic [2:0] DIE_LAST  = 3'(DIE_FRAMES - 1);

    animState_t  state;
    animState_t  reqState;
    animState_t  stateNext;
    logic [3:0]  tickCnt;
    logic [3:0]  tickNext;
    logic [2:0]  idxAdvanced;
    logic [2:0]  idxNext;
    logic        dirLatch;
    logic        dirNext;
    logic        doneNext;
    logic [20:0] baseNext;
    logic [20:0] offsetNext;

    always_comb begin
        if (dead)
            reqState = DIE;
        else if (jumping)
            reqState = JUMP;
        else if (moving)
            reqState = RUN;
        else
            reqState = IDLE;
    end

    always_comb begin
        idxAdvanced = 3'd0;
        case (state)
            IDLE: idxAdvanced = 3'd0;
            RUN:  idxAdvanced = (frameIndex == RUN_LAST)  ? 3'd0 : frameIndex + 3'd1;
            JUMP: idxAdvanced = (frameIndex == JUMP_LAST) ? 3'd0 : frameIndex + 3'd1;
            DIE:  idxAdvanced = (frameIndex == DIE_LAST)  ? frameIndex : frameIndex + 3'd1;
            default: idxAdvanced = 3'd0;
        endcase
    end

    // The direction captured on the DIE entry tick stays frozen afterwards.
    always_comb begin
        stateNext = state;
        idxNext   = frameIndex;
        tickNext  = tickCnt;
        dirNext   = dirLatch;

        if (state != DIE)
            dirNext = playerDirection;

        if (state != DIE && reqState != state) begin
            stateNext = reqState;
            idxNext   = 3'd0;
            tickNext  = 4'd0;
        end else if (tickCnt == TICK_LAST) begin
            tickNext = 4'd0;
            idxNext  = idxAdvanced;
        end else begin
            tickNext = tickCnt + 4'd1;
        end
    end

    always_comb begin
        baseNext = 21'd0;
        case (stateNext)
            IDLE: baseNext = 21'd0;
            RUN:  baseNext = 21'(RUN_BASE);
            JUMP: baseNext = 21'(JUMP_BASE);
            DIE:  baseNext = 21'(DIE_BASE);
            default: baseNext = 21'd0;
        endcase
    end

    // Outputs derive from next-state values so all registers move together.
    assign doneNext   = (stateNext == DIE) && (idxNext == DIE_LAST);
    assign offsetNext = (dirNext ? LEFT_BANK : 21'd0)
                      + (baseNext + 21'(idxNext)) * FRAME_SIZE;

    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            state       <= IDLE;
            frameIndex  <= 3'd0;
            tickCnt     <= 4'd0;
            dirLatch    <= 1'b0;
            frameOffset <= 21'd0;
            animDone    <= 1'b0;
        end else begin
            state       <= stateNext;
            frameIndex  <= idxNext;
            tickCnt     <= tickNext;
            dirLatch    <= dirNext;
            frameOffset <= offsetNext;
            animDone    <= doneNext;
        end
    end

    assign animState = state;

endmodule

// File: tb/tb_player_anim_sequencer.sv
// Directed and randomized bench for player_anim_sequencer against a model
// that derives frames from elapsed ticks since entering the current state.
module tb_player_anim_sequencer;

    localparam int TPF = 4;

    logic        frame_Clk;
    logic        Reset;
    logic        moving;
    logic        jumping;
    logic        dead;
    logic        playerDirection;
    logic [20:0] frameOffset;
    logic [1:0]  animState;
    logic [2:0]  frameIndex;
    logic        animDone;

    int checks = 0;
    int errors = 0;

    // reference model: current state, ticks elapsed since entry, facing
    int mState = 0;
    int mAge   = 0;
    int mDir   = 0;

    player_anim_sequencer dut (
        .frame_Clk      (frame_Clk),
        .Reset          (Reset),
        .moving         (moving),
        .jumping        (jumping),
        .dead           (dead),
        .playerDirection(playerDirection),
        .frameOffset    (frameOffset),
        .animState      (animState),
        .frameIndex     (frameIndex),
        .animDone       (animDone)
    );

    initial frame_Clk = 1'b0;
    always #5 frame_Clk = ~frame_Clk;

    function automatic int expIdx();
        int steps;
        steps = mAge / TPF;
        case (mState)
            1:       return steps % 6;
            2:       return steps % 4;
            3:       return (steps > 2) ? 2 : steps;
            default: return 0;
        endcase
    endfunction

    function automatic int expOffset();
        int base;
        case (mState)
            1:       base = 1;
            2:       base = 7;
            3:       base = 11;
            default: base = 0;
        endcase
        return mDir * 45696 + (base + expIdx()) * 3264;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame tick: drive inputs, clock, update model, compare all outputs.
    task automatic step(input bit r, input bit mv, input bit jp, input bit dd, input bit dr);
        int req;
        @(negedge frame_Clk);
        Reset = r; moving = mv; jumping = jp; dead = dd; playerDirection = dr;
        @(posedge frame_Clk);
        if (r) begin
            mState = 0; mAge = 0; mDir = 0;
        end else begin
            req = dd ? 3 : jp ? 2 : mv ? 1 : 0;
            if (mState != 3) mDir = dr;
            if (mState != 3 && req != mState) begin
                mState = req;
                mAge   = 0;
            end else begin
                mAge++;
            end
        end
        #1;
        chk("animState",   32'(animState),   32'(mState));
        chk("frameIndex",  32'(frameIndex),  32'(expIdx()));
        chk("frameOffset", 32'(frameOffset), 32'(expOffset()));
        chk("animDone",    32'(animDone),    32'((mState == 3 && expIdx() == 2) ? 1 : 0));
    endtask

    task automatic randStep();
        step(($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 15) == 0), 1'($urandom));
    endtask

    initial begin
        Reset = 1'b1; moving = 0; jumping = 0; dead = 0; playerDirection = 0;

        step(1, 0, 0, 0, 0);
        chk("reset_offset", 32'(frameOffset), 32'd0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);

        for (int i = 0; i < 30; i++) begin
            step(0, 1, 0, 0, 0);
            if (i == 0)  chk("run_entry_offset", 32'(frameOffset), 32'd3264);
            if (i == 20) chk("run_idx5_offset",  32'(frameOffset), 32'd19584);
            if (i == 24) chk("run_wrap_offset",  32'(frameOffset), 32'd3264);
        end

        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        chk("flip_offset", 32'(frameOffset), 32'd55488);
        chk("flip_index",  32'(frameIndex),  32'd2);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        chk("flip_cadence", 32'(frameIndex), 32'd3);

        step(0, 1, 1, 0, 0);
        chk("jump_state",  32'(animState),   32'd2);
        chk("jump_offset", 32'(frameOffset), 32'd22848);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("back_to_run", 32'(animState),  32'd1);
        chk("run_restart", 32'(frameIndex), 32'd0);

        step(0, 1, 1, 1, 1);
        chk("die_entry", 32'(frameOffset), 32'd81600);
        for (int i = 1; i <= 12; i++) begin
            step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if (i == 4) chk("die_idx1", 32'(frameOffset), 32'd84864);
            if (i == 8) chk("die_idx2", 32'(frameOffset), 32'd88128);
        end
        chk("die_done", 32'(animDone), 32'd1);

        step(1, 1, 1, 1, 1);
        chk("reset_state", 32'(animState), 32'd0);
        chk("reset_done",  32'(animDone),  32'd0);
        step(0, 1, 0, 0, 0);
        chk("post_reset_run", 32'(animState), 32'd1);

        for (int i = 0; i < 800; i++) randStep();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
